// File: rtl/csa_pkg.sv
// csa_pkg: shared constants and state encoding for the serial carry-save accumulator.
`default_nettype none

package csa_pkg;
  localparam int CSA_WIDTH     = 16;
  localparam int CSA_NUM_OPS   = 9;
  localparam int CSA_OUT_WIDTH = 20;
  localparam int CSA_CHUNK     = 4;
  localparam int CSA_CNT_W     = $clog2(CSA_NUM_OPS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } csa_state_e;
endpackage

`default_nettype wire

// File: rtl/csa_chunk_adder.sv
// csa_chunk_adder: CHUNK-bit ripple adder with carry-in and carry-out.
`default_nettype none

module csa_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co
);
  logic [CHUNK:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_ci};
  assign o_s     = w_total[CHUNK-1:0];
  assign o_co    = w_total[CHUNK];
endmodule

`default_nettype wire

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: serial carry-save accumulation with a chunked carry-propagate resolve.
// Optional macro CSA_EARLY_LAST_EN lets in_last terminate a transaction early.
`default_nettype none

module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = CSA_WIDTH,
  parameter int NUM_OPS   = CSA_NUM_OPS,
  parameter int OUT_WIDTH = CSA_OUT_WIDTH,
  parameter int CHUNK     = CSA_CHUNK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 busy
);
  localparam int NCHUNK = OUT_WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNT_W  = $clog2(NUM_OPS + 1);

  csa_state_e r_state, w_state_next;

  logic [OUT_WIDTH-1:0] r_s, r_c, r_sum;
  logic [CNT_W-1:0]     r_cnt;
  logic [KW-1:0]        r_k;
  logic                 r_carry, r_cout;

  logic                 w_accept, w_last_op, w_last_chunk;
  logic [OUT_WIDTH-1:0] w_x, w_s_base, w_c_base, w_s_next, w_c_next;
  logic [CHUNK-1:0]     w_chunk_sum;
  logic                 w_chunk_co;

  assign w_accept     = in_valid & in_ready;
  assign w_last_chunk = (r_k == KW'(NCHUNK - 1));

`ifdef CSA_EARLY_LAST_EN
  assign w_last_op = (r_cnt == CNT_W'(NUM_OPS - 1)) | in_last;
`else
  assign w_last_op = (r_cnt == CNT_W'(NUM_OPS - 1));
  logic w_unused_last;
  assign w_unused_last = in_last;
`endif

  // IDLE ignores stale S/C so the first beat simply loads S=x, C=0
  assign w_x      = {{(OUT_WIDTH - WIDTH){1'b0}}, in_data};
  assign w_s_base = (r_state == IDLE) ? '0 : r_s;
  assign w_c_base = (r_state == IDLE) ? '0 : r_c;
  assign w_s_next = w_s_base ^ w_c_base ^ w_x;
  assign w_c_next = ((w_s_base & w_c_base) | (w_s_base & w_x) | (w_c_base & w_x)) << 1;

  csa_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .i_a  (r_s[r_k*CHUNK +: CHUNK]),
    .i_b  (r_c[r_k*CHUNK +: CHUNK]),
    .i_ci (r_carry),
    .o_s  (w_chunk_sum),
    .o_co (w_chunk_co)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_last_op ? RESOLVE : ACCUM;
      ACCUM:   if (w_accept && w_last_op) w_state_next = RESOLVE;
      RESOLVE: if (w_last_chunk) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) || (r_state == ACCUM);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s     <= '0;
      r_c     <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_s     <= w_s_next;
      r_c     <= w_c_next;
      r_cnt   <= w_last_op ? '0 : r_cnt + 1'b1;
      r_k     <= '0;
      r_carry <= 1'b0;
    end else if (r_state == RESOLVE) begin
      r_sum[r_k*CHUNK +: CHUNK] <= w_chunk_sum;
      r_carry                   <= w_chunk_co;
      r_k                       <= r_k + 1'b1;
      if (w_last_chunk) r_cout <= w_chunk_co;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

`default_nettype wire
